// File: rtl/writeback_stage.sv
// MEM/WB commit stage: retires ALU results directly, holds loads until the data-memory
// response arrives, then aligns/extends the data and drives the register-file write port.
module writeback_stage #(
  parameter int unsigned RETIRE_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [4:0]              inRd,
  input  logic                    inRegWrite,
  input  logic                    inIsLoad,
  input  logic [2:0]              inFunct3,
  input  logic [1:0]              inAddrLow,
  input  logic [31:0]             inResult,
  input  logic                    memRespValid,
  input  logic [31:0]             memRespData,
  output logic                    writeEnable,
  output logic [4:0]              addressForWriting,
  output logic [31:0]             valueForWriting,
  output logic                    pendingLoadValid,
  output logic [4:0]              pendingLoadRd,
  output logic                    loadError,
  output logic [RETIRE_WIDTH-1:0] retiredCount
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'd0;
  localparam logic [F3_W-1:0] F3_LH  = 3'd1;
  localparam logic [F3_W-1:0] F3_LW  = 3'd2;
  localparam logic [F3_W-1:0] F3_LBU = 3'd4;
  localparam logic [F3_W-1:0] F3_LHU = 3'd5;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t              state;
  logic [REG_W-1:0]    ld_rd;
  logic                ld_regwrite;
  logic [F3_W-1:0]     ld_funct3;
  logic [1:0]          ld_addr;

  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_value;
  logic                ld_err;

  assign inReady = (state == IDLE);

  // Byte/halfword lane select and extension of the memory response for the latched load.
  always_comb begin
    ld_byte  = memRespData[7:0];
    ld_half  = memRespData[15:0];
    ld_value = '0;
    ld_err   = 1'b0;

    case (ld_addr)
      2'd1:    ld_byte = memRespData[15:8];
      2'd2:    ld_byte = memRespData[23:16];
      2'd3:    ld_byte = memRespData[31:24];
      default: ld_byte = memRespData[7:0];
    endcase

    if (ld_addr[1]) begin
      ld_half = memRespData[31:16];
    end

    case (ld_funct3)
      F3_LB:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU: ld_value = {24'd0, ld_byte};
      F3_LH: begin
        ld_value = {{16{ld_half[15]}}, ld_half};
        ld_err   = ld_addr[0];
      end
      F3_LHU: begin
        ld_value = {16'd0, ld_half};
        ld_err   = ld_addr[0];
      end
      F3_LW: begin
        ld_value = memRespData;
        ld_err   = (ld_addr != 2'd0);
      end
      default: ld_err = 1'b1;
    endcase
  end

  // Control FSM with registered write port, error pulse, pending-load status and retire counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      ld_rd             <= '0;
      ld_regwrite       <= 1'b0;
      ld_funct3         <= '0;
      ld_addr           <= '0;
      writeEnable       <= 1'b0;
      addressForWriting <= '0;
      valueForWriting   <= '0;
      loadError         <= 1'b0;
      pendingLoadValid  <= 1'b0;
      pendingLoadRd     <= '0;
      retiredCount      <= '0;
    end else begin
      writeEnable       <= 1'b0;
      addressForWriting <= '0;
      valueForWriting   <= '0;
      loadError         <= 1'b0;

      case (state)
        IDLE: begin
          if (inValid) begin
            if (inIsLoad) begin
              ld_rd            <= inRd;
              ld_regwrite      <= inRegWrite;
              ld_funct3        <= inFunct3;
              ld_addr          <= inAddrLow;
              pendingLoadValid <= 1'b1;
              pendingLoadRd    <= inRd;
              state            <= WAIT_LOAD;
            end else begin
              writeEnable       <= inRegWrite && (inRd != REG_W'(0));
              addressForWriting <= inRd;
              valueForWriting   <= inResult;
              retiredCount      <= retiredCount + RETIRE_WIDTH'(1);
            end
          end
        end

        WAIT_LOAD: begin
          if (memRespValid) begin
            pendingLoadValid <= 1'b0;
            pendingLoadRd    <= '0;
            state            <= IDLE;
            if (ld_err) begin
              loadError <= 1'b1;
            end else begin
              writeEnable       <= ld_regwrite && (ld_rd != REG_W'(0));
              addressForWriting <= ld_rd;
              valueForWriting   <= ld_value;
              retiredCount      <= retiredCount + RETIRE_WIDTH'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: per-cycle vector table plus reset-during-load and
// retire-counter wrap sequences.
module tb_writeback_stage;

  localparam int unsigned RW = 4;

  logic          clock;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [4:0]    inRd;
  logic          inRegWrite;
  logic          inIsLoad;
  logic [2:0]    inFunct3;
  logic [1:0]    inAddrLow;
  logic [31:0]   inResult;
  logic          memRespValid;
  logic [31:0]   memRespData;
  logic          writeEnable;
  logic [4:0]    addressForWriting;
  logic [31:0]   valueForWriting;
  logic          pendingLoadValid;
  logic [4:0]    pendingLoadRd;
  logic          loadError;
  logic [RW-1:0] retiredCount;

  int total = 0;
  int bad   = 0;

  writeback_stage #(.RETIRE_WIDTH(RW)) dut (
    .clock             (clock),
    .reset             (reset),
    .inValid           (inValid),
    .inReady           (inReady),
    .inRd              (inRd),
    .inRegWrite        (inRegWrite),
    .inIsLoad          (inIsLoad),
    .inFunct3          (inFunct3),
    .inAddrLow         (inAddrLow),
    .inResult          (inResult),
    .memRespValid      (memRespValid),
    .memRespData       (memRespData),
    .writeEnable       (writeEnable),
    .addressForWriting (addressForWriting),
    .valueForWriting   (valueForWriting),
    .pendingLoadValid  (pendingLoadValid),
    .pendingLoadRd     (pendingLoadRd),
    .loadError         (loadError),
    .retiredCount      (retiredCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] res;
    logic        rv;
    logic [31:0] data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wval;
    logic        err;
    logic        rdy;
    logic        pv;
    logic [4:0]  prd;
    logic [3:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] rd, logic rw, logic ld, logic [2:0] f3,
                              logic [1:0] a, logic [31:0] res, logic rv, logic [31:0] data,
                              logic we, logic [4:0] waddr, logic [31:0] wval, logic err,
                              logic rdy, logic pv, logic [4:0] prd, logic [3:0] cnt);
    vec_t t;
    t.v = v; t.rd = rd; t.rw = rw; t.ld = ld; t.f3 = f3; t.a = a; t.res = res;
    t.rv = rv; t.data = data; t.we = we; t.waddr = waddr; t.wval = wval; t.err = err;
    t.rdy = rdy; t.pv = pv; t.prd = prd; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    inValid      = t.v;
    inRd         = t.rd;
    inRegWrite   = t.rw;
    inIsLoad     = t.ld;
    inFunct3     = t.f3;
    inAddrLow    = t.a;
    inResult     = t.res;
    memRespValid = t.rv;
    memRespData  = t.data;
  endtask

  task automatic idle_inputs();
    inValid = 1'b0; inRd = '0; inRegWrite = 1'b0; inIsLoad = 1'b0; inFunct3 = '0;
    inAddrLow = '0; inResult = '0; memRespValid = 1'b0; memRespData = '0;
  endtask

  vec_t tbl[$];

  initial begin
    // v rd rw ld f3 a res rv data | we waddr wval err rdy pv prd cnt
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 32'h11, 0, 0,            1, 5, 32'h11, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 32'h22, 0, 0,            1, 6, 32'h22, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 32'h33, 0, 0,            1, 7, 32'h33, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 8, 1, 1, 0, 3, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 8, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 8, 3));
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 32'h99, 0, 0,            0, 0, 0, 0, 0, 1, 8, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000,     1, 8, 32'hFFFF_FF80, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 8, 1, 1, 4, 3, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 8, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000,     1, 8, 32'h0000_0080, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 10, 1, 1, 1, 2, 0, 0, 0,                0, 0, 0, 0, 0, 1, 10, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_1234,     1, 10, 32'hFFFF_8001, 0, 1, 0, 0, 6));
    tbl.push_back(mk(1, 10, 1, 1, 5, 2, 0, 0, 0,                0, 0, 0, 0, 0, 1, 10, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_1234,     1, 10, 32'h0000_8001, 0, 1, 0, 0, 7));
    tbl.push_back(mk(1, 11, 1, 1, 1, 1, 0, 0, 0,                0, 0, 0, 0, 0, 1, 11, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_1234,     0, 0, 0, 1, 1, 0, 0, 7));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 32'hDEAD_BEEF, 0, 0,     0, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678,     0, 0, 0, 0, 1, 0, 0, 8));
    tbl.push_back(mk(1, 12, 1, 1, 2, 0, 0, 0, 0,                0, 0, 0, 0, 0, 1, 12, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D,     1, 12, 32'hCAFE_F00D, 0, 1, 0, 0, 9));
    tbl.push_back(mk(1, 13, 1, 1, 2, 2, 0, 0, 0,                0, 0, 0, 0, 0, 1, 13, 9));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D,     0, 0, 0, 1, 1, 0, 0, 9));
    tbl.push_back(mk(1, 14, 1, 1, 3, 0, 0, 0, 0,                0, 0, 0, 0, 0, 1, 14, 9));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D,     0, 0, 0, 1, 1, 0, 0, 9));
    tbl.push_back(mk(1, 15, 0, 0, 0, 0, 32'h55, 0, 0,           0, 15, 32'h55, 0, 1, 0, 0, 10));
    tbl.push_back(mk(1, 16, 1, 1, 0, 1, 0, 0, 0,                0, 0, 0, 0, 0, 1, 16, 10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_7F00,     1, 16, 32'h0000_007F, 0, 1, 0, 0, 11));

    reset = 1'b0;
    idle_inputs();
    memRespValid = 1'b1;
    memRespData  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_we",   32'(writeEnable), 32'd0);
    chk("reset_addr", 32'(addressForWriting), 32'd0);
    chk("reset_val",  valueForWriting, 32'd0);
    chk("reset_err",  32'(loadError), 32'd0);
    chk("reset_pv",   32'(pendingLoadValid), 32'd0);
    chk("reset_prd",  32'(pendingLoadRd), 32'd0);
    chk("reset_cnt",  32'(retiredCount), 32'd0);
    chk("reset_rdy",  32'(inReady), 32'd1);

    reset = 1'b1;
    idle_inputs();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clock);
      chk($sformatf("v%0d_we", i),   32'(writeEnable), 32'(tbl[i].we));
      chk($sformatf("v%0d_addr", i), 32'(addressForWriting), 32'(tbl[i].waddr));
      chk($sformatf("v%0d_val", i),  valueForWriting, tbl[i].wval);
      chk($sformatf("v%0d_err", i),  32'(loadError), 32'(tbl[i].err));
      chk($sformatf("v%0d_rdy", i),  32'(inReady), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_pv", i),   32'(pendingLoadValid), 32'(tbl[i].pv));
      chk($sformatf("v%0d_prd", i),  32'(pendingLoadRd), 32'(tbl[i].prd));
      chk($sformatf("v%0d_cnt", i),  32'(retiredCount), 32'(tbl[i].cnt));
    end

    // Reset while a load is outstanding; the late response must be dropped.
    idle_inputs();
    inValid = 1'b1; inIsLoad = 1'b1; inRd = 5'd8; inRegWrite = 1'b1; inAddrLow = 2'd3;
    @(negedge clock);
    chk("rst_wait_pv",  32'(pendingLoadValid), 32'd1);
    chk("rst_wait_rdy", 32'(inReady), 32'd0);
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    memRespValid = 1'b1;
    memRespData  = 32'h80FF_0000;
    @(negedge clock);
    idle_inputs();
    chk("rst_late_we",  32'(writeEnable), 32'd0);
    chk("rst_late_pv",  32'(pendingLoadValid), 32'd0);
    chk("rst_late_prd", 32'(pendingLoadRd), 32'd0);
    chk("rst_late_cnt", 32'(retiredCount), 32'd0);
    chk("rst_late_rdy", 32'(inReady), 32'd1);

    // Counter wrap: 15 retirements to all-ones, then one more.
    for (int k = 0; k < 15; k++) begin
      inValid = 1'b1; inIsLoad = 1'b0; inRd = 5'd1; inRegWrite = 1'b1; inResult = 32'(k);
      @(negedge clock);
    end
    chk("wrap_full", 32'(retiredCount), 32'd15);
    inResult = 32'hA5A5_0001;
    @(negedge clock);
    idle_inputs();
    chk("wrap_zero", 32'(retiredCount), 32'd0);
    chk("wrap_we",   32'(writeEnable), 32'd1);
    chk("wrap_val",  valueForWriting, 32'hA5A5_0001);
    @(negedge clock);
    chk("wrap_pulse_end", 32'(writeEnable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
